key_event_ctrl: RTL and testbench
=================================

# key_event_ctrl

Key-event controller between the PS/2 byte receiver and the game logic. Consumes one-cycle scan-code strobes and resolves the E0 (extended) and F0 (break) prefixes into make/break events. Tracks held state for the game keys and turns key makes into one-cycle game commands (flap, pause toggle, restart) with typematic repeats suppressed. Queues every resolved event in a small FIFO for the game logic, which reads it over a valid/ready handshake.

## Interface
Parameters:
- FIFO_DEPTH, 4, event queue depth; power of two, ≥2
- PREFIX_TIMEOUT, 2_000_000, cycles allowed between a prefix and its following code before the prefix is discarded (20 ms at 100 MHz)

Ports:
- clk  in  1  system clock; one clock
- rst  in  1  reset; synchronous and active-high
- kb_code  in  8  receiver output; a nonzero value is a one-cycle byte strobe, 8'h00 means idle
- flap  out  1  one-cycle pulse on a make of Space (0x29) or Up (E0 75)
- pause_tgl  out  1  one-cycle pulse on a make of P (0x4D) or Esc (0x76)
- restart  out  1  one-cycle pulse on a make of R (0x2D)
- held  out  4  held flags {R, P/Esc, Up, Space}
- ev_valid  out  1  FIFO head valid
- ev_ready  in  1  consumer accepts the head when ev_valid & ev_ready
- ev_data  out  10  {brk, ext, code[7:0]} of the FIFO head
- ovf  out  1  sticky flag; set when an event is dropped on a full FIFO

## Operation
- Prefix FSM states:
  - IDLE: E0 → EXT; F0 → BRK; any other nonzero code → resolve(ext=0, brk=0).
  - EXT: F0 → EXT_BRK; E0 → stay in EXT; other code → resolve(1, 0), then IDLE.
  - BRK: E0 → EXT_BRK; F0 → stay in BRK; other code → resolve(0, 1), then IDLE.
  - EXT_BRK: F0 or E0 → stay; other code → resolve(1, 1), then IDLE.
- Timeout: a counter clears on every strobe and runs in every non-IDLE state. When it reaches PREFIX_TIMEOUT-1 the FSM returns to IDLE with no event.
- resolve pushes {brk, ext, code} into the FIFO. Unrecognised codes are queued but produce no command.
- Key map: Space = ext 0, 0x29; Up = ext 1, 0x75; P = ext 0, 0x4D; Esc = ext 0, 0x76; R = ext 0, 0x2D. The ext bit must match. E0 29 is not Space.
- Make of a mapped key:
  - If its held bit is 0, set the bit and pulse the command.
  - If the bit is already 1 (typematic repeat), pulse nothing.
- P and Esc share one held bit and one command.
- Break of a mapped key clears its held bit. No command pulse.
- FIFO is circular with power-of-two pointer wrap.
  - Push when full and no pop in the same cycle: the event is dropped and ovf is set.
  - Push and pop in the same cycle when full: both succeed.
  - Push and pop in the same cycle when empty: the push happens, the pop is ignored (ev_valid was 0).
- Reset values: FSM = IDLE, timeout counter 0, held 0, flap/pause_tgl/restart 0, FIFO empty (ev_valid 0, ev_data 0), ovf 0.
- rst asserted mid-prefix or while the FIFO is non-empty discards all state in the next cycle.

## Timing
- Latency: the strobe of the final code byte arrives at edge N. Command pulses and the held update are visible after edge N (one cycle). The event is visible on ev_valid after edge N when the FIFO was empty.
- A pop completes at the edge where ev_valid & ev_ready is high. ev_data advances to the next entry after that edge.
- ev_data and ev_valid must stay stable while ev_valid & ~ev_ready.
- Back-to-back strobes on consecutive cycles are accepted. The receiver guarantees ≥10 cycles between strobes; the block does not depend on that spacing.
- Outputs are registered. There is no combinational path from kb_code or ev_ready to any output.

## Structure
- A shared package holds:
  - scan-code constants: SC_E0, SC_F0, SC_SPACE, SC_UP, SC_P, SC_ESC, SC_R
  - the FSM state enum
  - the ev_data field positions
- Natural sub-module: key_event_fifo, a generic synchronous FIFO with parameterised width/depth, push/pop, full/empty. The FSM, key map and held logic stay in key_event_ctrl.

## Test plan
- Space make (29), then typematic 29 ×3, then F0 29 → one flap pulse; held[0] goes 1 then 0; FIFO carries {0,0,29} ×4 and {1,0,29}.
- E0 75 → flap pulse, held[1]=1. E0 F0 75 → held[1]=0 and event {1,1,75}. E0 29 → no flap, event {0,1,29}.
- F0 followed by 2_000_000 idle cycles, then 2D → FSM back in IDLE; R make produces a restart pulse (not a break); held[3]=1.
- Push 5 events with ev_ready=0 and FIFO_DEPTH=4 → 4 queued, ovf=1. Drain with ev_ready=1 → the first 4 events in order, ev_valid then 0.
- FIFO full, ev_ready=1 and a new strobe in the same cycle → no drop, ovf stays 0, order preserved.
- rst pulsed after E0 F0 with 2 events queued → ev_valid 0, held 0, ovf 0. A following 75 resolves as make {0,0,75}.

Source files
------------

// File: rtl/key_event_ctrl_pkg.sv
// Shared constants, FSM state type and event-word layout for the key-event controller.
package key_event_ctrl_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_R     = 8'h2D;

    localparam int EV_W        = 10;
    localparam int EV_BRK      = 9;
    localparam int EV_EXT      = 8;
    localparam int EV_CODE_LSB = 0;

    localparam logic [1:0] KEY_SPACE = 2'd0;
    localparam logic [1:0] KEY_UP    = 2'd1;
    localparam logic [1:0] KEY_PAUSE = 2'd2;
    localparam logic [1:0] KEY_R     = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } key_hit_t;

    // The ext bit is part of the key identity: E0 29 is not Space.
    function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] code);
        key_hit_t r;
        r = '0;
        if (!ext && code == SC_SPACE)                  r = '{1'b1, KEY_SPACE};
        else if (ext && code == SC_UP)                 r = '{1'b1, KEY_UP};
        else if (!ext && (code == SC_P || code == SC_ESC)) r = '{1'b1, KEY_PAUSE};
        else if (!ext && code == SC_R)                 r = '{1'b1, KEY_R};
        return r;
    endfunction

endpackage

// File: rtl/key_event_if.sv
// Valid/ready event stream from the key-event controller to the game logic.
interface key_event_if;
    import key_event_ctrl_pkg::*;

    logic            ev_valid;
    logic            ev_ready;
    logic [EV_W-1:0] ev_data;

    modport master (output ev_valid, output ev_data, input ev_ready);
    modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/key_event_fifo.sv
// Generic synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module key_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             pop_ok, push_ok;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_ok  = pop_i & ~empty_o;
    // A pop on a full queue frees the slot the push lands in.
    assign push_ok = push_i & (~full_o | pop_ok);
    assign drop_o  = push_i & ~push_ok;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Resolves E0/F0 prefixed scan codes into make/break events, game commands and held flags.
module key_event_ctrl
    import key_event_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int PREFIX_TIMEOUT = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  kb_code,
    output logic        flap,
    output logic        pause_tgl,
    output logic        restart,
    output logic [3:0]  held,
    output logic        ovf,
    key_event_if.master ev
);
    localparam int CNT_W = $clog2(PREFIX_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

    state_e          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]      held_q;
    logic            flap_q, pause_q, restart_q, ovf_q;

    logic            strobe, resolve, res_ext, res_brk, drop, fifo_full, fifo_empty;
    logic [EV_W-1:0] ev_word;
    key_hit_t        kh;

    always_comb begin
        strobe  = (kb_code != 8'h00);
        resolve = strobe && (kb_code != SC_E0) && (kb_code != SC_F0);
        res_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        res_brk = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        ev_word = '0;
        ev_word[EV_BRK] = res_brk;
        ev_word[EV_EXT] = res_ext;
        ev_word[EV_CODE_LSB +: 8] = kb_code;
        kh = key_lookup(res_ext, kb_code);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            held_q    <= '0;
            flap_q    <= 1'b0;
            pause_q   <= 1'b0;
            restart_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            flap_q    <= 1'b0;
            pause_q   <= 1'b0;
            restart_q <= 1'b0;
            ovf_q     <= ovf_q | drop;

            if (strobe) begin
                cnt_q <= '0;
                if (resolve)
                    state_q <= ST_IDLE;
                else if (kb_code == SC_E0)
                    state_q <= (state_q == ST_IDLE || state_q == ST_EXT) ? ST_EXT : ST_EXT_BRK;
                else
                    state_q <= (state_q == ST_IDLE || state_q == ST_BRK) ? ST_BRK : ST_EXT_BRK;
            end else if (state_q != ST_IDLE) begin
                if (cnt_q == CNT_LAST) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            // Only the first make after a release fires; typematic repeats are absorbed.
            if (resolve && kh.hit) begin
                if (res_brk) begin
                    held_q[kh.idx] <= 1'b0;
                end else if (!held_q[kh.idx]) begin
                    held_q[kh.idx] <= 1'b1;
                    flap_q    <= (kh.idx == KEY_SPACE) || (kh.idx == KEY_UP);
                    pause_q   <= (kh.idx == KEY_PAUSE);
                    restart_q <= (kh.idx == KEY_R);
                end
            end
        end
    end

    key_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (resolve),
        .pop_i   (ev.ev_ready),
        .din_i   (ev_word),
        .dout_o  (ev.ev_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (drop)
    );

    assign ev.ev_valid = ~fifo_empty;
    assign flap        = flap_q;
    assign pause_tgl   = pause_q;
    assign restart     = restart_q;
    assign held        = held_q;
    assign ovf         = ovf_q;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: table of single-cycle vectors plus hand-written corner sequences.
module tb_key_event_ctrl;
    localparam int T_OUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] kb_code;
    logic       flap, pause_tgl, restart, ovf;
    logic [3:0] held;

    key_event_if ev_if ();

    key_event_ctrl #(
        .FIFO_DEPTH     (4),
        .PREFIX_TIMEOUT (T_OUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .kb_code   (kb_code),
        .flap      (flap),
        .pause_tgl (pause_tgl),
        .restart   (restart),
        .held      (held),
        .ovf       (ovf),
        .ev        (ev_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       rdy;
        logic       flap;
        logic       pause;
        logic       rstp;
        logic [3:0] held;
        logic       vld;
        logic [9:0] data;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t v(input logic [7:0] c, input logic r, input logic f, input logic p,
                               input logic rs, input logic [3:0] h, input logic vl, input logic [9:0] d);
        vec_t x;
        x.code = c; x.rdy = r; x.flap = f; x.pause = p; x.rstp = rs;
        x.held = h; x.vld = vl; x.data = d;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: apply inputs, take the edge, release the strobe; outputs are read 1 time unit later.
    task automatic drive(input logic [7:0] c, input logic r);
        kb_code = c;
        ev_if.ev_ready = r;
        @(posedge clk);
        #1;
        kb_code = 8'h00;
    endtask

    initial begin
        rst = 1'b1;
        kb_code = 8'h00;
        ev_if.ev_ready = 1'b0;
        drive(8'h00, 1'b0);
        drive(8'h00, 1'b0);
        chk("reset_flap", flap, 0);
        chk("reset_pause", pause_tgl, 0);
        chk("reset_restart", restart, 0);
        chk("reset_held", held, 0);
        chk("reset_valid", ev_if.ev_valid, 0);
        chk("reset_data", ev_if.ev_data, 0);
        chk("reset_ovf", ovf, 0);
        rst = 1'b0;

        //          code  rdy f  p  r  held  v  data
        tbl.push_back(v(8'h29, 0, 1, 0, 0, 4'h1, 1, 10'h029));
        tbl.push_back(v(8'h00, 1, 0, 0, 0, 4'h1, 0, 10'h000));
        tbl.push_back(v(8'h29, 0, 0, 0, 0, 4'h1, 1, 10'h029));
        tbl.push_back(v(8'h00, 1, 0, 0, 0, 4'h1, 0, 10'h000));
        tbl.push_back(v(8'h29, 0, 0, 0, 0, 4'h1, 1, 10'h029));
        tbl.push_back(v(8'h00, 1, 0, 0, 0, 4'h1, 0, 10'h000));
        tbl.push_back(v(8'h29, 0, 0, 0, 0, 4'h1, 1, 10'h029));
        tbl.push_back(v(8'h00, 1, 0, 0, 0, 4'h1, 0, 10'h000));
        tbl.push_back(v(8'hF0, 0, 0, 0, 0, 4'h1, 0, 10'h000));
        tbl.push_back(v(8'h29, 0, 0, 0, 0, 4'h0, 1, 10'h229));
        tbl.push_back(v(8'h00, 1, 0, 0, 0, 4'h0, 0, 10'h000));
        tbl.push_back(v(8'hE0, 0, 0, 0, 0, 4'h0, 0, 10'h000));
        tbl.push_back(v(8'h75, 0, 1, 0, 0, 4'h2, 1, 10'h175));
        tbl.push_back(v(8'h00, 1, 0, 0, 0, 4'h2, 0, 10'h000));
        tbl.push_back(v(8'hE0, 0, 0, 0, 0, 4'h2, 0, 10'h000));
        tbl.push_back(v(8'hF0, 0, 0, 0, 0, 4'h2, 0, 10'h000));
        tbl.push_back(v(8'h75, 0, 0, 0, 0, 4'h0, 1, 10'h375));
        tbl.push_back(v(8'h00, 1, 0, 0, 0, 4'h0, 0, 10'h000));
        tbl.push_back(v(8'hE0, 0, 0, 0, 0, 4'h0, 0, 10'h000));
        tbl.push_back(v(8'h29, 0, 0, 0, 0, 4'h0, 1, 10'h129));
        tbl.push_back(v(8'h00, 1, 0, 0, 0, 4'h0, 0, 10'h000));
        tbl.push_back(v(8'h4D, 0, 0, 1, 0, 4'h4, 1, 10'h04D));
        tbl.push_back(v(8'h00, 1, 0, 0, 0, 4'h4, 0, 10'h000));
        tbl.push_back(v(8'h76, 0, 0, 0, 0, 4'h4, 1, 10'h076));
        tbl.push_back(v(8'h00, 1, 0, 0, 0, 4'h4, 0, 10'h000));
        tbl.push_back(v(8'hF0, 0, 0, 0, 0, 4'h4, 0, 10'h000));
        tbl.push_back(v(8'h76, 0, 0, 0, 0, 4'h0, 1, 10'h276));
        tbl.push_back(v(8'h00, 1, 0, 0, 0, 4'h0, 0, 10'h000));
        tbl.push_back(v(8'h76, 0, 0, 1, 0, 4'h4, 1, 10'h076));
        tbl.push_back(v(8'h00, 1, 0, 0, 0, 4'h4, 0, 10'h000));
        tbl.push_back(v(8'h2D, 0, 0, 0, 1, 4'hC, 1, 10'h02D));
        tbl.push_back(v(8'h00, 1, 0, 0, 0, 4'hC, 0, 10'h000));
        tbl.push_back(v(8'hF0, 0, 0, 0, 0, 4'hC, 0, 10'h000));
        tbl.push_back(v(8'h2D, 0, 0, 0, 0, 4'h4, 1, 10'h22D));
        tbl.push_back(v(8'h00, 1, 0, 0, 0, 4'h4, 0, 10'h000));
        tbl.push_back(v(8'hF0, 0, 0, 0, 0, 4'h4, 0, 10'h000));
        tbl.push_back(v(8'h4D, 0, 0, 0, 0, 4'h0, 1, 10'h24D));
        tbl.push_back(v(8'h00, 1, 0, 0, 0, 4'h0, 0, 10'h000));
        tbl.push_back(v(8'h12, 0, 0, 0, 0, 4'h0, 1, 10'h012));
        tbl.push_back(v(8'h00, 1, 0, 0, 0, 4'h0, 0, 10'h000));
        tbl.push_back(v(8'hE0, 0, 0, 0, 0, 4'h0, 0, 10'h000));
        tbl.push_back(v(8'hE0, 0, 0, 0, 0, 4'h0, 0, 10'h000));
        tbl.push_back(v(8'h75, 0, 1, 0, 0, 4'h2, 1, 10'h175));
        tbl.push_back(v(8'h00, 1, 0, 0, 0, 4'h2, 0, 10'h000));
        tbl.push_back(v(8'hF0, 0, 0, 0, 0, 4'h2, 0, 10'h000));
        tbl.push_back(v(8'hE0, 0, 0, 0, 0, 4'h2, 0, 10'h000));
        tbl.push_back(v(8'h75, 0, 0, 0, 0, 4'h0, 1, 10'h375));
        tbl.push_back(v(8'h00, 1, 0, 0, 0, 4'h0, 0, 10'h000));

        foreach (tbl[i]) begin
            drive(tbl[i].code, tbl[i].rdy);
            chk($sformatf("vec%0d_flap", i), flap, tbl[i].flap);
            chk($sformatf("vec%0d_pause", i), pause_tgl, tbl[i].pause);
            chk($sformatf("vec%0d_restart", i), restart, tbl[i].rstp);
            chk($sformatf("vec%0d_held", i), held, tbl[i].held);
            chk($sformatf("vec%0d_valid", i), ev_if.ev_valid, tbl[i].vld);
            chk($sformatf("vec%0d_data", i), ev_if.ev_data, tbl[i].data);
            chk($sformatf("vec%0d_ovf", i), ovf, 0);
        end

        // Prefix expires after T_OUT idle cycles: the following 2D is a make.
        drive(8'hF0, 1'b0);
        repeat (T_OUT) drive(8'h00, 1'b0);
        drive(8'h2D, 1'b0);
        chk("tmo_restart", restart, 1);
        chk("tmo_held", held, 4'h8);
        chk("tmo_data", ev_if.ev_data, 10'h02D);
        drive(8'h00, 1'b1);
        chk("tmo_drained", ev_if.ev_valid, 0);

        // One cycle short of the timeout the prefix still applies.
        drive(8'hF0, 1'b0);
        repeat (T_OUT - 1) drive(8'h00, 1'b0);
        drive(8'h2D, 1'b0);
        chk("tmo_edge_restart", restart, 0);
        chk("tmo_edge_held", held, 4'h0);
        chk("tmo_edge_data", ev_if.ev_data, 10'h22D);
        drive(8'h00, 1'b1);

        // Full FIFO with simultaneous pop and push.
        for (int i = 0; i < 4; i++) drive(8'h21 + 8'(i), 1'b0);
        chk("full_valid", ev_if.ev_valid, 1);
        chk("full_head", ev_if.ev_data, 10'h021);
        drive(8'h25, 1'b1);
        chk("pp_ovf", ovf, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pp_order%0d", i), ev_if.ev_data, 10'h022 + 10'(i));
            drive(8'h00, 1'b1);
        end
        chk("pp_empty", ev_if.ev_valid, 0);

        // Overflow: five pushes into a four-deep queue.
        for (int i = 0; i < 4; i++) drive(8'h11 + 8'(i), 1'b0);
        chk("ovf_before", ovf, 0);
        drive(8'h15, 1'b0);
        chk("ovf_set", ovf, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_valid%0d", i), ev_if.ev_valid, 1);
            chk($sformatf("ovf_order%0d", i), ev_if.ev_data, 10'h011 + 10'(i));
            drive(8'h00, 1'b1);
        end
        chk("ovf_empty", ev_if.ev_valid, 0);
        chk("ovf_sticky", ovf, 1);

        // Reset in the middle of a prefix with events queued.
        drive(8'h29, 1'b0);
        drive(8'h31, 1'b0);
        drive(8'hE0, 1'b0);
        drive(8'hF0, 1'b0);
        chk("pre_rst_valid", ev_if.ev_valid, 1);
        chk("pre_rst_held", held, 4'h1);
        rst = 1'b1;
        drive(8'h00, 1'b0);
        rst = 1'b0;
        chk("rst_valid", ev_if.ev_valid, 0);
        chk("rst_held", held, 4'h0);
        chk("rst_ovf", ovf, 0);
        chk("rst_data", ev_if.ev_data, 10'h000);
        drive(8'h75, 1'b0);
        chk("rst_make_data", ev_if.ev_data, 10'h075);
        chk("rst_make_flap", flap, 0);
        chk("rst_make_held", held, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
